// File: rtl/ray_dispatch_pkg.sv
// Shared definitions for the ray dispatch front-end.
//   - Default coordinate widths. They follow the frame-buffer resolution
//     macros, so a resolution change in one place propagates here.
//   - Dispatch state enumeration used by the top-level controller.
`ifndef RD_FB_X_WIDTH
`define RD_FB_X_WIDTH 10
`endif
`ifndef RD_FB_Y_WIDTH
`define RD_FB_Y_WIDTH 9
`endif

package ray_dispatch_pkg;

    localparam int unsigned RD_X_WIDTH      = `RD_FB_X_WIDTH;
    localparam int unsigned RD_Y_WIDTH      = `RD_FB_Y_WIDTH;
    localparam int unsigned RD_MAX_INFLIGHT = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } dispatch_state_e;

endpackage

// File: rtl/ray_dispatch_scan.sv
// Raster x/y counter for the ray dispatcher.
// Walks x fastest, then y, and returns to (0,0) after the last pixel so the
// coordinate outputs rest at the origin between frames.
// Ports:
//   clk, resetn     clock and asynchronous active-low reset
//   load            clear the position to (0,0)
//   advance         step to the next pixel in raster order
//   width, height   frame dimensions (held stable by the caller)
//   pixel_x/y       current position (registered)
//   last_pixel      current position is the final pixel of the frame
module ray_dispatch_scan
    import ray_dispatch_pkg::*;
#(
    parameter int unsigned X_WIDTH = RD_X_WIDTH,
    parameter int unsigned Y_WIDTH = RD_Y_WIDTH
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               load,
    input  logic               advance,
    input  logic [X_WIDTH-1:0] width,
    input  logic [Y_WIDTH-1:0] height,
    output logic [X_WIDTH-1:0] pixel_x,
    output logic [Y_WIDTH-1:0] pixel_y,
    output logic               last_pixel
);

    logic [X_WIDTH-1:0] x_r;
    logic [X_WIDTH-1:0] x_next_s;
    logic [Y_WIDTH-1:0] y_r;
    logic [Y_WIDTH-1:0] y_next_s;
    logic               last_col_s;
    logic               last_row_s;

    // End-of-row / end-of-column decode against the frame dimensions.
    always_comb begin
        last_col_s = (x_r == (width  - X_WIDTH'(1)));
        last_row_s = (y_r == (height - Y_WIDTH'(1)));
    end

    // Next raster position: load wins, then advance with row/frame wrap.
    always_comb begin
        x_next_s = x_r;
        y_next_s = y_r;
        if (load) begin
            x_next_s = X_WIDTH'(0);
            y_next_s = Y_WIDTH'(0);
        end else if (advance) begin
            if (last_col_s) begin
                x_next_s = X_WIDTH'(0);
                if (last_row_s) begin
                    y_next_s = Y_WIDTH'(0);
                end else begin
                    y_next_s = y_r + Y_WIDTH'(1);
                end
            end else begin
                x_next_s = x_r + X_WIDTH'(1);
                y_next_s = y_r;
            end
        end else begin
            x_next_s = x_r;
            y_next_s = y_r;
        end
    end

    // Position registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_r <= X_WIDTH'(0);
            y_r <= Y_WIDTH'(0);
        end else begin
            x_r <= x_next_s;
            y_r <= y_next_s;
        end
    end

    assign pixel_x    = x_r;
    assign pixel_y    = y_r;
    assign last_pixel = last_col_s && last_row_s;

endmodule

// File: rtl/ray_dispatch.sv
// Ray dispatch front-end: issues one primary-ray pixel per accepted cycle to
// the ray core's raster input, throttles on in-flight rays, and detects frame
// completion by counting shader-stage retirements.
// Ports:
//   clk, resetn                 clock and asynchronous active-low reset
//   start                       begin a frame (honoured only when idle)
//   frame_width, frame_height   frame size, sampled on an accepted start
//   fifo_full                   ray core input FIFO cannot take a pixel
//   add_input                   pixel_x/pixel_y valid and accepted this cycle
//   pixel_x, pixel_y            current raster position
//   ret_valid                   one pulse per retired primary ray
//   busy                        accepted start until frame_done
//   frame_done                  single-cycle completion pulse
//   issued_count/retired_count  per-frame ray counts, held after completion
//   ret_error                   sticky: retirement seen with nothing in flight
module ray_dispatch
    import ray_dispatch_pkg::*;
#(
    parameter int unsigned X_WIDTH      = RD_X_WIDTH,
    parameter int unsigned Y_WIDTH      = RD_Y_WIDTH,
    parameter int unsigned MAX_INFLIGHT = RD_MAX_INFLIGHT,
    parameter int unsigned CNT_WIDTH    = X_WIDTH + Y_WIDTH
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [X_WIDTH-1:0]   frame_width,
    input  logic [Y_WIDTH-1:0]   frame_height,
    input  logic                 fifo_full,
    output logic                 add_input,
    output logic [X_WIDTH-1:0]   pixel_x,
    output logic [Y_WIDTH-1:0]   pixel_y,
    input  logic                 ret_valid,
    output logic                 busy,
    output logic                 frame_done,
    output logic [CNT_WIDTH-1:0] issued_count,
    output logic [CNT_WIDTH-1:0] retired_count,
    output logic                 ret_error
);

    // Counter must represent 0..MAX_INFLIGHT inclusive.
    localparam int unsigned          IF_WIDTH       = $clog2(MAX_INFLIGHT + 1);
    localparam logic [IF_WIDTH-1:0]  INFLIGHT_LIMIT = IF_WIDTH'(MAX_INFLIGHT);

    dispatch_state_e      state_r;
    dispatch_state_e      state_next_s;
    logic [X_WIDTH-1:0]   width_r;
    logic [Y_WIDTH-1:0]   height_r;
    logic [CNT_WIDTH-1:0] issued_r;
    logic [CNT_WIDTH-1:0] retired_r;
    logic [IF_WIDTH-1:0]  inflight_r;
    logic                 busy_r;
    logic                 frame_done_r;
    logic                 ret_error_r;

    logic                 start_ok_s;
    logic                 dims_zero_s;
    logic                 add_input_s;
    logic                 ret_accept_s;
    logic                 ret_stray_s;
    logic                 last_pixel_s;

    // Handshake and retirement qualification. add_input is the only
    // combinational output: it must see fifo_full in the same cycle.
    always_comb begin
        start_ok_s   = (state_r == ST_IDLE) && start;
        dims_zero_s  = (frame_width == X_WIDTH'(0)) || (frame_height == Y_WIDTH'(0));
        add_input_s  = (state_r == ST_ISSUE) && !fifo_full && (inflight_r < INFLIGHT_LIMIT);
        ret_accept_s = ret_valid && (inflight_r != IF_WIDTH'(0));
        ret_stray_s  = ret_valid && (inflight_r == IF_WIDTH'(0));
    end

    // Frame walk over the latched dimensions.
    ray_dispatch_scan #(
        .X_WIDTH (X_WIDTH),
        .Y_WIDTH (Y_WIDTH)
    ) u_scan (
        .clk        (clk),
        .resetn     (resetn),
        .load       (start_ok_s),
        .advance    (add_input_s),
        .width      (width_r),
        .height     (height_r),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .last_pixel (last_pixel_s)
    );

    // Dispatch FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = dims_zero_s ? ST_DONE : ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (add_input_s && last_pixel_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (retired_r == issued_r) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Dispatch FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Frame dimensions, captured only on an accepted start.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            width_r  <= X_WIDTH'(0);
            height_r <= Y_WIDTH'(0);
        end else if (start_ok_s) begin
            width_r  <= frame_width;
            height_r <= frame_height;
        end else begin
            width_r  <= width_r;
            height_r <= height_r;
        end
    end

    // Per-frame issue count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            issued_r <= CNT_WIDTH'(0);
        end else if (start_ok_s) begin
            issued_r <= CNT_WIDTH'(0);
        end else if (add_input_s) begin
            issued_r <= issued_r + CNT_WIDTH'(1);
        end else begin
            issued_r <= issued_r;
        end
    end

    // Per-frame retire count; stray retirements are not counted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            retired_r <= CNT_WIDTH'(0);
        end else if (start_ok_s) begin
            retired_r <= CNT_WIDTH'(0);
        end else if (ret_accept_s) begin
            retired_r <= retired_r + CNT_WIDTH'(1);
        end else begin
            retired_r <= retired_r;
        end
    end

    // In-flight tracker; a same-cycle issue and retire cancel out.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inflight_r <= IF_WIDTH'(0);
        end else begin
            case ({add_input_s, ret_accept_s})
                2'b10:   inflight_r <= inflight_r + IF_WIDTH'(1);
                2'b01:   inflight_r <= inflight_r - IF_WIDTH'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // Busy spans accepted start through the DONE cycle; frame_done marks
    // the single DONE cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= (state_next_s == ST_DONE);
            if (start_ok_s) begin
                busy_r <= 1'b1;
            end else if (state_r == ST_DONE) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
        end
    end

    // Sticky error for retirements that have no matching in-flight ray.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ret_error_r <= 1'b0;
        end else if (ret_stray_s) begin
            ret_error_r <= 1'b1;
        end else begin
            ret_error_r <= ret_error_r;
        end
    end

    assign add_input     = add_input_s;
    assign busy          = busy_r;
    assign frame_done    = frame_done_r;
    assign issued_count  = issued_r;
    assign retired_count = retired_r;
    assign ret_error     = ret_error_r;

endmodule

// File: tb/tb_ray_dispatch.sv
// Self-checking bench for ray_dispatch. A frame-level reference model
// (pixel index, in-flight total, counts) predicts every output each cycle;
// retirements come from a queue of due times filled as the model issues.
module tb_ray_dispatch;

    localparam int XW   = 10;
    localparam int YW   = 9;
    localparam int MAXI = 4;
    localparam int CW   = XW + YW;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [XW-1:0] frame_width;
    logic [YW-1:0] frame_height;
    logic          fifo_full;
    logic          add_input;
    logic [XW-1:0] pixel_x;
    logic [YW-1:0] pixel_y;
    logic          ret_valid;
    logic          busy;
    logic          frame_done;
    logic [CW-1:0] issued_count;
    logic [CW-1:0] retired_count;
    logic          ret_error;

    always #5 clk = ~clk;

    ray_dispatch #(
        .X_WIDTH      (XW),
        .Y_WIDTH      (YW),
        .MAX_INFLIGHT (MAXI),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .start         (start),
        .frame_width   (frame_width),
        .frame_height  (frame_height),
        .fifo_full     (fifo_full),
        .add_input     (add_input),
        .pixel_x       (pixel_x),
        .pixel_y       (pixel_y),
        .ret_valid     (ret_valid),
        .busy          (busy),
        .frame_done    (frame_done),
        .issued_count  (issued_count),
        .retired_count (retired_count),
        .ret_error     (ret_error)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase 0 idle, 1 issuing, 2 draining, 3 done.
    int m_phase = 0;
    int m_w = 0;
    int m_h = 0;
    int m_idx = 0;
    int m_ret = 0;
    int m_inflight = 0;
    bit m_err = 1'b0;

    int cyc = 0;
    int due_q[$];
    int lat_min = 3;
    int lat_max = 3;
    int hold_until = 0;
    int done_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit ff_of(input int mode);
        if (mode == 1) return (cyc % 2) == 0;
        if (mode == 2) return $urandom_range(0, 2) == 0;
        return 1'b0;
    endfunction

    // One clock: drive inputs, check outputs at negedge, advance model at posedge.
    task automatic cycle(input bit st, input bit ff, input bit stray, input int w, input int h);
        bit exp_add;
        bit rv;
        bit ok;
        int k;
        int lat;
        k = -1;
        if (cyc >= hold_until) begin
            foreach (due_q[i]) begin
                if (k < 0 && due_q[i] <= cyc) k = i;
            end
        end
        rv           = stray || (k >= 0);
        start        = st;
        fifo_full    = ff;
        ret_valid    = rv;
        frame_width  = w[XW-1:0];
        frame_height = h[YW-1:0];
        exp_add = (m_phase == 1) && !ff && (m_inflight < MAXI);

        @(negedge clk);
        check("add_input",  32'(add_input),  32'(exp_add));
        check("pixel_x",    32'(pixel_x),    (m_phase == 1) ? (m_idx % m_w) : 0);
        check("pixel_y",    32'(pixel_y),    (m_phase == 1) ? (m_idx / m_w) : 0);
        check("busy",       32'(busy),       32'(m_phase != 0));
        check("frame_done", 32'(frame_done), 32'(m_phase == 3));
        check("issued",     32'(issued_count),  m_idx);
        check("retired",    32'(retired_count), m_ret);
        check("ret_error",  32'(ret_error),  32'(m_err));
        if (frame_done) done_seen++;

        @(posedge clk);
        ok = rv && (m_inflight > 0);
        if (rv && m_inflight == 0) m_err = 1'b1;
        if (k >= 0) due_q.delete(k);
        case (m_phase)
            0: if (st) begin
                m_w = w[XW-1:0];
                m_h = h[YW-1:0];
                m_idx = 0;
                m_ret = 0;
                m_phase = (m_w == 0 || m_h == 0) ? 3 : 1;
            end
            1: if (exp_add) begin
                m_idx++;
                if (m_idx == m_w * m_h) m_phase = 2;
            end
            2: if (m_ret == m_idx) m_phase = 3;
            default: m_phase = 0;
        endcase
        if (ok) m_ret++;
        m_inflight = m_inflight + int'(exp_add) - int'(ok);
        if (exp_add) begin
            lat = $urandom_range(lat_max, lat_min);
            due_q.push_back(cyc + lat);
        end
        cyc++;
        #1;
    endtask

    // Start a frame and run until the model returns to idle; spurious
    // starts with junk dimensions are thrown in while busy.
    task automatic run_frame(input int w, input int h, input int mode, input bit junk);
        int n;
        cycle(1'b1, ff_of(mode), 1'b0, w, h);
        n = 0;
        while (m_phase != 0 && n < 3000) begin
            cycle(junk && ($urandom_range(0, 5) == 0), ff_of(mode), 1'b0,
                  int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)));
            n++;
        end
        check("frame_timeout", 32'(m_phase == 0), 32'd1);
    endtask

    initial begin
        int n;
        resetn = 1'b0;
        start = 1'b0;
        fifo_full = 1'b0;
        ret_valid = 1'b0;
        frame_width = '0;
        frame_height = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Reset state plus a few idle cycles.
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 0, 0);

        // 4x2 frame, no back-pressure, retire 3 cycles after issue.
        lat_min = 3; lat_max = 3; done_seen = 0;
        run_frame(4, 2, 0, 1'b0);
        check("t1_issued",  32'(issued_count), 32'd8);
        check("t1_retired", 32'(retired_count), 32'd8);
        check("t1_done_pulses", 32'(done_seen), 32'd1);

        // 3x3 frame with fifo_full toggling every cycle.
        lat_min = 1; lat_max = 5;
        run_frame(3, 3, 1, 1'b1);
        check("t2_issued", 32'(issued_count), 32'd9);

        // 8x1 frame, retirements held back for 10 cycles: throttle at MAXI.
        lat_min = 1; lat_max = 1;
        hold_until = cyc + 10;
        run_frame(8, 1, 0, 1'b0);
        hold_until = 0;
        check("t3_issued", 32'(issued_count), 32'd8);

        // Zero-width frame: straight to completion.
        done_seen = 0;
        run_frame(0, 5, 0, 1'b0);
        check("t4_done_pulses", 32'(done_seen), 32'd1);
        check("t4_issued", 32'(issued_count), 32'd0);

        // Stray retirement while idle, then a normal 2x2 frame.
        cycle(1'b0, 1'b0, 1'b1, 0, 0);
        cycle(1'b0, 1'b0, 1'b0, 0, 0);
        check("t5_err_set", 32'(ret_error), 32'd1);
        lat_min = 1; lat_max = 4;
        run_frame(2, 2, 0, 1'b0);
        check("t5_err_sticky", 32'(ret_error), 32'd1);
        check("t5_retired", 32'(retired_count), 32'd4);

        // Asynchronous reset in the middle of a 16x16 frame.
        lat_min = 2; lat_max = 6;
        cycle(1'b1, 1'b0, 1'b0, 16, 16);
        n = 0;
        while (m_idx < 20 && n < 500) begin
            cycle(1'b0, ff_of(2), 1'b0, 16, 16);
            n++;
        end
        check("t6_reach20", 32'(m_idx >= 20), 32'd1);
        start = 1'b0;
        ret_valid = 1'b0;
        fifo_full = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check("rst_add_input", 32'(add_input), 32'd0);
        check("rst_pixel_x", 32'(pixel_x), 32'd0);
        check("rst_pixel_y", 32'(pixel_y), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_issued", 32'(issued_count), 32'd0);
        check("rst_retired", 32'(retired_count), 32'd0);
        check("rst_ret_error", 32'(ret_error), 32'd0);
        m_phase = 0; m_idx = 0; m_ret = 0; m_inflight = 0; m_err = 1'b0;
        due_q.delete();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        run_frame(3, 2, 0, 1'b0);
        // A ray from before the reset comes back: nothing is in flight.
        cycle(1'b0, 1'b0, 1'b1, 0, 0);
        cycle(1'b0, 1'b0, 1'b0, 0, 0);
        check("t6_late_ret_err", 32'(ret_error), 32'd1);

        // Randomized frames, back-pressure modes and retire latencies.
        for (int f = 0; f < 20; f++) begin
            int w;
            int h;
            w = $urandom_range(0, 7) == 0 ? 0 : int'($urandom_range(1, 6));
            h = int'($urandom_range(1, 5));
            lat_min = int'($urandom_range(1, 3));
            lat_max = lat_min + int'($urandom_range(0, 6));
            run_frame(w, h, int'($urandom_range(0, 2)), 1'b1);
            for (int i = 0; i < 3; i++) begin
                cycle(1'b0, 1'b0, $urandom_range(0, 9) == 0, 0, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
